systolic_feed_sequencer: RTL and testbench

Sequences one convolution tile through the column systolic MAC datapath. It issues weight-buffer and feature-buffer reads and produces the `wt_vld`/`wt_sel`/`dat_vld`/`Wout_loop_start`/`Wout_loop_end` stream the MAC control consumes. Weights for the next K-pass are preloaded into the MAC's staging registers while the current pass streams. The block sits between the tile-level layer controller (start/done) and the feature/weight buffers plus MAC control.

---
 rtl/systolic_feed_sequencer.sv | 173 +++++++++++++++++
 tb/tb_systolic_feed_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_sequencer.sv
// Sequences one convolution tile: weight preload, Wout feature loops per K-pass, background weight prefetch, drain.
// Latency: read strobes are combinational on state and ready; every *_vld/sel/loop flag trails its strobe by 1 cycle.
// Backpressure: wt_rdy low holds the weight row index; dat_rdy low only delays the first beat of a loop.
module systolic_feed_sequencer #(
  parameter int TOUT      = 16,
  parameter int LOG2TOUT  = 4,
  parameter int WOUT_W    = 12,
  parameter int KLOOP_W   = 10,
  parameter int DRAIN_CYC = 36
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WOUT_W-1:0]   cfg_wout,
  input  logic [KLOOP_W-1:0]  cfg_kloops,
  input  logic [3:0]          cfg_tin_factor,
  output logic [3:0]          tin_factor,
  output logic                busy,
  output logic                done,
  input  logic                wt_rdy,
  output logic                wt_rd_en,
  output logic [LOG2TOUT-1:0] wt_rd_idx,
  input  logic                dat_rdy,
  output logic                dat_rd_en,
  output logic                wt_vld,
  output logic [LOG2TOUT-1:0] wt_sel,
  output logic                dat_vld,
  output logic                Wout_loop_start,
  output logic                Wout_loop_end
);

  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [LOG2TOUT-1:0] LAST_ROW   = LOG2TOUT'(TOUT - 1);
  // DRAIN plus the one-cycle DONE state plus the registered done flag place
  // done exactly DRAIN_CYC cycles after the final dat_vld.
  localparam logic [DW-1:0]       DRAIN_LAST = DW'(DRAIN_CYC - 2);

  typedef enum logic [2:0] {IDLE, PRELOAD, STREAM, WAIT, DRAIN, DONE} state_t;

  state_t               state;
  logic [WOUT_W-1:0]    wout_q;
  logic [WOUT_W-1:0]    beat_cnt;
  logic [WOUT_W-1:0]    beat_nxt;
  logic [KLOOP_W-1:0]   kloops_q;
  logic [KLOOP_W-1:0]   pass_cnt;
  logic [KLOOP_W-1:0]   pass_nxt;
  logic [LOG2TOUT-1:0]  rd_idx;
  logic [DW-1:0]        drain_cnt;
  logic                 wt_full;     // all rows of the next pass to stream are staged
  logic                 ld_en;       // background loader fetching pass k+1
  logic                 streaming;   // inside a Wout loop, past its first beat
  logic                 ld_last;
  logic                 first_beat;
  logic                 last_beat;
  logic                 more_passes;
  logic                 next_ready;

  assign wt_rd_idx   = rd_idx;
  assign wt_rd_en    = wt_rdy && ((state == PRELOAD) || ld_en);
  assign ld_last     = wt_rd_en && (rd_idx == LAST_ROW);
  assign first_beat  = (state == STREAM) && !streaming && wt_full && dat_rdy;
  assign dat_rd_en   = (state == STREAM) && (streaming || (wt_full && dat_rdy));
  assign beat_nxt    = beat_cnt + WOUT_W'(1);
  assign last_beat   = dat_rd_en && (beat_nxt == wout_q);
  assign pass_nxt    = pass_cnt + KLOOP_W'(1);
  assign more_passes = (pass_nxt != kloops_q);
  // A staged set consumed by this very beat does not count for the next loop.
  assign next_ready  = (wt_full && !first_beat) || ld_last;

  // Tile FSM: config latch, loop/pass/drain counting, busy and done flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wout_q     <= '0;
      kloops_q   <= '0;
      tin_factor <= '0;
      pass_cnt   <= '0;
      beat_cnt   <= '0;
      streaming  <= 1'b0;
      drain_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            wout_q     <= cfg_wout;
            kloops_q   <= cfg_kloops;
            tin_factor <= cfg_tin_factor;
            pass_cnt   <= '0;
            beat_cnt   <= '0;
            streaming  <= 1'b0;
            drain_cnt  <= '0;
            busy       <= 1'b1;
            state      <= (cfg_wout == '0 || cfg_kloops == '0) ? DONE : PRELOAD;
          end
        end
        PRELOAD: begin
          if (ld_last) state <= STREAM;
        end
        STREAM: begin
          if (dat_rd_en) begin
            if (last_beat) begin
              streaming <= 1'b0;
              beat_cnt  <= '0;
              if (more_passes) begin
                pass_cnt <= pass_nxt;
                state    <= next_ready ? STREAM : WAIT;
              end else begin
                drain_cnt <= '0;
                state     <= DRAIN;
              end
            end else begin
              streaming <= 1'b1;
              beat_cnt  <= beat_nxt;
            end
          end
        end
        WAIT: begin
          if (wt_full || ld_last) state <= STREAM;
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= DONE;
          else drain_cnt <= drain_cnt + DW'(1);
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Weight row index and staging status; the loader arms the cycle after a loop's first beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx  <= '0;
      wt_full <= 1'b0;
      ld_en   <= 1'b0;
    end else begin
      if (ld_last) rd_idx <= '0;
      else if (wt_rd_en) rd_idx <= rd_idx + LOG2TOUT'(1);
      if (ld_last) begin
        wt_full <= 1'b1;
        ld_en   <= 1'b0;
      end else if (first_beat) begin
        wt_full <= 1'b0;
        ld_en   <= more_passes;
      end
    end
  end

  // One-cycle delayed copies of the read-side strobes, aligned with buffer data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wt_vld          <= 1'b0;
      wt_sel          <= '0;
      dat_vld         <= 1'b0;
      Wout_loop_start <= 1'b0;
      Wout_loop_end   <= 1'b0;
    end else begin
      wt_vld          <= wt_rd_en;
      wt_sel          <= rd_idx;
      dat_vld         <= dat_rd_en;
      Wout_loop_start <= first_beat;
      Wout_loop_end   <= last_beat;
    end
  end

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Directed bench for systolic_feed_sequencer: per-cycle traces compared to hand-derived cycle sets.
// Cycle n is the window after clock edge n-1; start is sampled at edge 0.
// Ready stalls are applied per cycle from the run arguments.
module tb_systolic_feed_sequencer;

  localparam int TOUT      = 16;
  localparam int LOG2TOUT  = 4;
  localparam int WOUT_W    = 12;
  localparam int KLOOP_W   = 10;
  localparam int DRAIN_CYC = 36;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [WOUT_W-1:0]   cfg_wout;
  logic [KLOOP_W-1:0]  cfg_kloops;
  logic [3:0]          cfg_tin_factor;
  logic [3:0]          tin_factor;
  logic                busy;
  logic                done;
  logic                wt_rdy;
  logic                wt_rd_en;
  logic [LOG2TOUT-1:0] wt_rd_idx;
  logic                dat_rdy;
  logic                dat_rd_en;
  logic                wt_vld;
  logic [LOG2TOUT-1:0] wt_sel;
  logic                dat_vld;
  logic                Wout_loop_start;
  logic                Wout_loop_end;

  always #5 clk = ~clk;

  systolic_feed_sequencer #(
    .TOUT(TOUT), .LOG2TOUT(LOG2TOUT), .WOUT_W(WOUT_W), .KLOOP_W(KLOOP_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_wout(cfg_wout), .cfg_kloops(cfg_kloops), .cfg_tin_factor(cfg_tin_factor),
    .tin_factor(tin_factor), .busy(busy), .done(done),
    .wt_rdy(wt_rdy), .wt_rd_en(wt_rd_en), .wt_rd_idx(wt_rd_idx),
    .dat_rdy(dat_rdy), .dat_rd_en(dat_rd_en),
    .wt_vld(wt_vld), .wt_sel(wt_sel), .dat_vld(dat_vld),
    .Wout_loop_start(Wout_loop_start), .Wout_loop_end(Wout_loop_end)
  );

  logic [19:0] ov;
  assign ov = {busy, done, tin_factor, wt_rd_en, wt_rd_idx, dat_rd_en, wt_vld, wt_sel,
               dat_vld, Wout_loop_start, Wout_loop_end};

  logic [127:0] tr_wr, tr_dr, tr_wv, tr_dv, tr_ls, tr_le, tr_dn, tr_bz, tr_any;
  logic [63:0]  sel_seq;
  logic [3:0]   tin_mid;
  int tests = 0;
  int fails = 0;

  function automatic logic [127:0] rng(input int lo, input int hi);
    logic [127:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One tile: start at cycle 0, then ncyc cycles of per-cycle stimulus and trace capture.
  task automatic run(input int wout, input int kl, input int ws_lo, input int ws_hi,
                     input int dr_from, input int ncyc, input int rst_cyc, input int bs_cyc);
    tr_wr = '0; tr_dr = '0; tr_wv = '0; tr_dv = '0; tr_ls = '0;
    tr_le = '0; tr_dn = '0; tr_bz = '0; tr_any = '0;
    sel_seq = '0; tin_mid = '0;
    cfg_wout = WOUT_W'(wout);
    cfg_kloops = KLOOP_W'(kl);
    cfg_tin_factor = 4'd4;
    start = 1'b1;
    wt_rdy = 1'b1;
    dat_rdy = (dr_from <= 0);
    @(posedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      #1;
      start = (n == bs_cyc);
      if (n == bs_cyc) begin
        cfg_wout = 12'd1;
        cfg_kloops = 10'd1;
        cfg_tin_factor = 4'd8;
      end
      wt_rdy = !(n >= ws_lo && n <= ws_hi);
      dat_rdy = (n >= dr_from);
      if (n == rst_cyc) rst = 1'b1;
      #1;
      tr_wr[n] = wt_rd_en;
      tr_dr[n] = dat_rd_en;
      tr_wv[n] = wt_vld;
      tr_dv[n] = dat_vld;
      tr_ls[n] = Wout_loop_start;
      tr_le[n] = Wout_loop_end;
      tr_dn[n] = done;
      tr_bz[n] = busy;
      tr_any[n] = |ov;
      if (wt_vld) sel_seq = {sel_seq[59:0], wt_sel};
      if (n == 50) tin_mid = tin_factor;
      @(posedge clk);
    end
    #1 start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_wout = '0; cfg_kloops = '0; cfg_tin_factor = '0;
    wt_rdy = 1'b0; dat_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", 128'(ov), '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Nominal 2-pass tile, with an ignored start (and changed cfg) at cycle 40.
    run(20, 2, 1000, 0, 0, 100, 0, 40);
    chk("nom_wt_rd_en",  tr_wr, rng(1, 16) | rng(18, 33));
    chk("nom_dat_rd_en", tr_dr, rng(17, 56));
    chk("nom_wt_vld",    tr_wv, rng(2, 17) | rng(19, 34));
    chk("nom_dat_vld",   tr_dv, rng(18, 57));
    chk("nom_loop_start", tr_ls, rng(18, 18) | rng(38, 38));
    chk("nom_loop_end",  tr_le, rng(37, 37) | rng(57, 57));
    chk("nom_done",      tr_dn, rng(93, 93));
    chk("nom_busy",      tr_bz, rng(1, 93));
    chk("nom_tin_factor", 128'(tin_mid), 128'(4'd4));
    repeat (3) @(posedge clk);
    #1;

    // Short loop: loop 1 waits for the pass-1 weights.
    run(8, 2, 1000, 0, 0, 90, 0, 0);
    chk("short_wt_rd_en",  tr_wr, rng(1, 16) | rng(18, 33));
    chk("short_dat_rd_en", tr_dr, rng(17, 24) | rng(34, 41));
    chk("short_loop_start", tr_ls, rng(18, 18) | rng(35, 35));
    chk("short_loop_end",  tr_le, rng(25, 25) | rng(42, 42));
    chk("short_done",      tr_dn, rng(78, 78));
    repeat (3) @(posedge clk);
    #1;

    // Weight stall in PRELOAD, cycles 5..9.
    run(20, 1, 5, 9, 0, 90, 0, 0);
    chk("wstall_wt_rd_en",  tr_wr, rng(1, 4) | rng(10, 21));
    chk("wstall_dat_rd_en", tr_dr, rng(22, 41));
    chk("wstall_wt_sel_seq", 128'(sel_seq), 128'(64'h0123456789ABCDEF));
    chk("wstall_done",      tr_dn, rng(78, 78));
    repeat (3) @(posedge clk);
    #1;

    // Feature stall: dat_rdy low until cycle 30.
    run(20, 2, 1000, 0, 30, 110, 0, 0);
    chk("fstall_wt_rd_en",  tr_wr, rng(1, 16) | rng(31, 46));
    chk("fstall_dat_rd_en", tr_dr, rng(30, 69));
    chk("fstall_loop_start", tr_ls, rng(31, 31) | rng(51, 51));
    chk("fstall_done",      tr_dn, rng(106, 106));
    repeat (3) @(posedge clk);
    #1;

    // Degenerate configs.
    run(5, 0, 1000, 0, 0, 10, 0, 0);
    chk("k0_wt_rd_en",  tr_wr, '0);
    chk("k0_dat_rd_en", tr_dr, '0);
    chk("k0_done",      tr_dn, rng(2, 2));
    chk("k0_busy",      tr_bz, rng(1, 2));
    repeat (2) @(posedge clk);
    #1;
    run(0, 3, 1000, 0, 0, 10, 0, 0);
    chk("w0_done",      tr_dn, rng(2, 2));
    chk("w0_dat_rd_en", tr_dr, '0);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-STREAM at cycle 25, then a fresh nominal tile.
    run(20, 2, 1000, 0, 0, 40, 25, 0);
    chk("rst_dat_rd_en", tr_dr, rng(17, 24));
    chk("rst_any_output", tr_any, rng(1, 24));
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(20, 2, 1000, 0, 0, 100, 0, 0);
    chk("post_rst_wt_rd_en",  tr_wr, rng(1, 16) | rng(18, 33));
    chk("post_rst_dat_rd_en", tr_dr, rng(17, 56));
    chk("post_rst_done",      tr_dn, rng(93, 93));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
